// File: rtl/rv32_e_div_unit.sv
// rv32_e_div_unit
// ---------------
// Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU group.
// It takes one operation at a time and computes one quotient bit per cycle.
// Operations whose ALU code is not one of the four divide codes are ignored.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   valid_i        operation request
//   alu_control_i  decoded ALU operation
//   op_a_i         dividend (rs1)
//   op_b_i         divisor (rs2)
//   ready_o        unit is idle and can accept an operation
//   flush_i        abort any in-flight operation and drop its result
//   valid_o        result_o holds a finished result
//   ready_i        writeback consumes the result
//   result_o       quotient or remainder
//
// Build option
//   DIV_FAST_SPECIAL_EN  When defined, divide-by-zero, signed overflow and
//                        |a| < |b| bypass the 32 iteration cycles. Their
//                        result is then ready one cycle after accept. The
//                        results are identical in both builds.

module rv32_e_div_unit #(
   parameter int XLEN              = 32,
   parameter int ALU_CONTROL_WIDTH = 5
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         valid_i,
   input  logic [ALU_CONTROL_WIDTH-1:0] alu_control_i,
   input  logic [XLEN-1:0]              op_a_i,
   input  logic [XLEN-1:0]              op_b_i,
   output logic                         ready_o,
   input  logic                         flush_i,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [XLEN-1:0]              result_o
);

   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_DIV  = ALU_CONTROL_WIDTH'(14);
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_DIVU = ALU_CONTROL_WIDTH'(15);
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_REM  = ALU_CONTROL_WIDTH'(16);
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_REMU = ALU_CONTROL_WIDTH'(17);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e          state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [XLEN:0]   r_q, r_d;        // partial remainder
   logic [XLEN-1:0] q_q, q_d;        // dividend shifting out, quotient shifting in
   logic [XLEN-1:0] b_q, b_d;        // divisor magnitude
   logic            want_rem_q, want_rem_d;
   logic            neg_q_q, neg_q_d;
   logic            neg_r_q, neg_r_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            is_div_code, op_signed, op_rem, accept;
   logic [XLEN-1:0] abs_a, abs_b;
   logic [XLEN:0]   r_shift, r_sub;
   logic            r_ge;
   logic [XLEN-1:0] quo_fix, rem_fix;
   logic            r_msb_unused;

   assign is_div_code = (alu_control_i == ALU_DIV)  || (alu_control_i == ALU_DIVU) ||
                        (alu_control_i == ALU_REM)  || (alu_control_i == ALU_REMU);
   assign op_signed   = (alu_control_i == ALU_DIV)  || (alu_control_i == ALU_REM);
   assign op_rem      = (alu_control_i == ALU_REM)  || (alu_control_i == ALU_REMU);
   assign accept      = (state_q == IDLE) && valid_i && is_div_code && !flush_i;

   assign abs_a = (op_signed && op_a_i[XLEN-1]) ? (~op_a_i + 1'b1) : op_a_i;
   assign abs_b = (op_signed && op_b_i[XLEN-1]) ? (~op_b_i + 1'b1) : op_b_i;

   // Restoring step. The remainder stays below |b| between steps, so its top
   // bit is always zero and only the lower XLEN bits feed the next shift.
   assign r_shift      = {r_q[XLEN-1:0], q_q[XLEN-1]};
   assign r_sub        = r_shift - {1'b0, b_q};
   assign r_ge         = (r_shift >= {1'b0, b_q});
   assign r_msb_unused = r_q[XLEN];

   // A zero divisor leaves an all-ones quotient that must not be negated.
   assign quo_fix = (neg_q_q && (b_q != '0)) ? (~q_q + 1'b1) : q_q;
   assign rem_fix = neg_r_q ? (~r_q[XLEN-1:0] + 1'b1) : r_q[XLEN-1:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      r_d        = r_q;
      q_d        = q_q;
      b_d        = b_q;
      want_rem_d = want_rem_q;
      neg_q_d    = neg_q_q;
      neg_r_d    = neg_r_q;
      result_d   = result_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               want_rem_d = op_rem;
               neg_q_d    = op_signed && (op_a_i[XLEN-1] ^ op_b_i[XLEN-1]);
               neg_r_d    = op_signed && op_a_i[XLEN-1];
               b_d        = abs_b;
               q_d        = abs_a;
               r_d        = '0;
               cnt_d      = 6'd32;
               state_d    = CALC;
`ifdef DIV_FAST_SPECIAL_EN
               // Preload the magnitudes that the full iteration would reach
               // and let the single fixup cycle produce the final result.
               if (abs_b == '0) begin
                  q_d   = '1;
                  r_d   = {1'b0, abs_a};
                  cnt_d = 6'd0;
               end else if (op_signed && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                            (op_b_i == '1)) begin
                  q_d   = {1'b1, {(XLEN-1){1'b0}}};
                  r_d   = '0;
                  cnt_d = 6'd0;
               end else if (abs_a < abs_b) begin
                  q_d   = '0;
                  r_d   = {1'b0, abs_a};
                  cnt_d = 6'd0;
               end
`endif
            end
         end
         CALC: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (cnt_q != 6'd0) begin
               r_d   = r_ge ? r_sub : r_shift;
               q_d   = {q_q[XLEN-2:0], r_ge};
               cnt_d = cnt_q - 6'd1;
            end else begin
               result_d = want_rem_q ? rem_fix : quo_fix;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (flush_i || ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         r_q        <= '0;
         q_q        <= '0;
         b_q        <= '0;
         want_rem_q <= 1'b0;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         r_q        <= r_d;
         q_q        <= q_d;
         b_q        <= b_d;
         want_rem_q <= want_rem_d;
         neg_q_q    <= neg_q_d;
         neg_r_q    <= neg_r_d;
         result_q   <= result_d;
      end
   end

   assign ready_o  = (state_q == IDLE);
   assign valid_o  = (state_q == DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_rv32_e_div_unit.sv
// Directed testbench for rv32_e_div_unit. Expected results are hand-computed
// RISC-V values; expected latency follows the build option.
module tb_rv32_e_div_unit;

   localparam logic [4:0] ALU_MUL  = 5'd10;
   localparam logic [4:0] ALU_DIV  = 5'd14;
   localparam logic [4:0] ALU_DIVU = 5'd15;
   localparam logic [4:0] ALU_REM  = 5'd16;
   localparam logic [4:0] ALU_REMU = 5'd17;
`ifdef DIV_FAST_SPECIAL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        valid_i = 1'b0;
   logic [4:0]  alu_control_i = 5'd0;
   logic [31:0] op_a_i = 32'd0;
   logic [31:0] op_b_i = 32'd0;
   logic        ready_o;
   logic        flush_i = 1'b0;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [31:0] result_o;

   int total = 0;
   int bad   = 0;

   rv32_e_div_unit dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .valid_i       (valid_i),
      .alu_control_i (alu_control_i),
      .op_a_i        (op_a_i),
      .op_b_i        (op_b_i),
      .ready_o       (ready_o),
      .flush_i       (flush_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .result_o      (result_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input logic [4:0] code, input logic [31:0] a,
                                  input logic [31:0] b);
      logic        sg;
      logic [31:0] aa, bb;
      logic        special;
      sg = (code == ALU_DIV) || (code == ALU_REM);
      aa = (sg && a[31]) ? (32'd0 - a) : a;
      bb = (sg && b[31]) ? (32'd0 - b) : b;
      special = (b == 32'd0) || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (aa < bb);
      return (FAST && special) ? 1 : 33;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!ready_o && n < 200) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk("wait_ready", {31'd0, ready_o}, 32'd1);
   endtask

   task automatic accept_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
      wait_ready();
      valid_i = 1'b1; alu_control_i = code; op_a_i = a; op_b_i = b;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
      int lat = 0;
      accept_op(code, a, b);
      while (!valid_o && lat < 100) begin
         @(posedge clk_i); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat(code, a, b));
      chk({tag, "_res"}, result_o, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk_i); #1;
         chk({tag, "_hold_v"}, {31'd0, valid_o}, 32'd1);
         chk({tag, "_hold_r"}, result_o, exp);
      end
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      ready_i = 1'b0;
      chk({tag, "_consumed"}, {31'd0, valid_o}, 32'd0);
      chk({tag, "_idle"}, {31'd0, ready_o}, 32'd1);
      $display("op %s a=0x%08h b=0x%08h result=0x%08h latency=%0d", tag, a, b, exp, lat);
   endtask

   initial begin
      int seen;
      #2;
      chk("rst_ready", {31'd0, ready_o}, 32'd1);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_result", result_o, 32'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      do_op("div_20_m3",   ALU_DIV,  32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 0);
      do_op("rem_20_m3",   ALU_REM,  32'd20,         32'hFFFF_FFFD, 32'h0000_0002, 0);
      do_op("rem_m20_3",   ALU_REM,  32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 0);
      do_op("divu_max_2",  ALU_DIVU, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 0);
      do_op("remu_max_2",  ALU_REMU, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 0);
      do_op("div_m7_0",    ALU_DIV,  32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 0);
      do_op("rem_m7_0",    ALU_REM,  32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 0);
      do_op("divu_5_0",    ALU_DIVU, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
      do_op("div_ovf",     ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
      do_op("rem_ovf",     ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 0);
      do_op("div_3_7",     ALU_DIV,  32'd3,          32'd7,         32'h0000_0000, 0);
      do_op("rem_m3_7",    ALU_REM,  32'hFFFF_FFFD,  32'd7,         32'hFFFF_FFFD, 0);
      do_op("divu_bp",     ALU_DIVU, 32'd1000,       32'd7,         32'd142,       5);
      do_op("remu_bp",     ALU_REMU, 32'd1000,       32'd7,         32'd6,         5);

      // Non-divide code: no accept, nothing produced.
      valid_i = 1'b1; alu_control_i = ALU_MUL; op_a_i = 32'd6; op_b_i = 32'd7;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i); #1;
         if (!ready_o || valid_o) seen++;
      end
      valid_i = 1'b0;
      chk("mul_ignored", seen, 32'd0);
      $display("op mul_filter a=0x%08h b=0x%08h not accepted", 32'd6, 32'd7);

      // Flush 10 cycles after accept.
      accept_op(ALU_DIV, 32'd100, 32'd7);
      repeat (9) @(posedge clk_i);
      #1 flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      chk("flush_ready", {31'd0, ready_o}, 32'd1);
      chk("flush_valid", {31'd0, valid_o}, 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i); #1;
         if (valid_o) seen++;
      end
      chk("flush_no_valid", seen, 32'd0);
      $display("op flush_div a=0x%08h b=0x%08h dropped", 32'd100, 32'd7);

      // Asynchronous reset mid-calculation.
      accept_op(ALU_DIVU, 32'd12345, 32'd11);
      repeat (5) @(posedge clk_i);
      #3 rst_ni = 1'b0;
      #1;
      chk("arst_ready", {31'd0, ready_o}, 32'd1);
      chk("arst_valid", {31'd0, valid_o}, 32'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      $display("op reset_mid_calc a=0x%08h b=0x%08h aborted", 32'd12345, 32'd11);

      // Unit still works after the reset.
      do_op("divu_post_rst", ALU_DIVU, 32'd12345, 32'd11, 32'd1122, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
